// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Multi-channel register write-back unit for the general and
//            float register files. NCH producers request writes over
//            valid/ready. One request is granted per cycle in round-robin
//            order. The granted write goes to the register file one cycle
//            later as a one-hot enable vector plus data. A busy scoreboard
//            tracks pending destinations so that issue logic can stall.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  data width of one register
//   NREG   registers per file (general and float each)
//   AW     register index width, log2(NREG)
//   NCH    number of producer channels
// Ports
//   clk         in   1          clock, rising edge
//   rst         in   1          asynchronous reset, active-high
//   in_valid    in   NCH        request valid per channel
//   in_ready    out  NCH        combinational grant per channel
//   in_gf       in   NCH        per-channel file select (0 general, 1 float)
//   in_num      in   NCH*AW     per-channel register index, ch i at [i*AW +: AW]
//   in_data     in   NCH*WIDTH  per-channel write data, ch i at [i*WIDTH +: WIDTH]
//   rsv_valid   in   1          reserve a destination this cycle
//   rsv_gf      in   1          file select of the reservation
//   rsv_num     in   AW         register index of the reservation
//   wr_data     out  WIDTH      registered write data
//   wr_enables  out  2*NREG     registered one-hot enable; general [NREG-1:0],
//                               float [2*NREG-1:NREG]
//   busy        out  2*NREG     scoreboard, same layout as wr_enables
// Build option
//   REG_WB_ZERO_GUARD_EN  when defined, general register 0 is hardwired to
//                         zero: writes to it are accepted but never
//                         enabled, and it is never marked busy.
// ============================================================================
module reg_wb_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int NCH   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [NCH-1:0]       in_gf,
   input  logic [NCH*AW-1:0]    in_num,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic                 rsv_valid,
   input  logic                 rsv_gf,
   input  logic [AW-1:0]        rsv_num,
   output logic [WIDTH-1:0]     wr_data,
   output logic [2*NREG-1:0]    wr_enables,
   output logic [2*NREG-1:0]    busy
);

   localparam int c_PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int c_NB = 2 * NREG;

   // -------------------------------------------------------------------------
   // Map {file, index} to a one-hot bit in the combined 2*NREG space.
   // Out-of-range indices (possible only when NREG is not a power of two)
   // map to an all-zero vector, which drops the write and leaves the
   // scoreboard untouched.
   // -------------------------------------------------------------------------
   function automatic logic [c_NB-1:0] f_onehot(input logic          gf,
                                                input logic [AW-1:0] num);
      logic [c_NB-1:0] v;
      int              idx;
      v   = '0;
      idx = int'(num) + (gf ? NREG : 0);
      if (int'(num) < NREG) begin
         for (int i = 0; i < c_NB; i++) begin
            if (i == idx) v[i] = 1'b1;
         end
      end
`ifdef REG_WB_ZERO_GUARD_EN
      // General r0 is constant zero: never written, never busy.
      if (!gf && (num == '0)) v = '0;
`endif
      return v;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [c_PW-1:0]  r_ptr;
   logic [WIDTH-1:0] r_wr_data;
   logic [c_NB-1:0]  r_wr_enables;
   logic [c_NB-1:0]  r_busy;

   // -------------------------------------------------------------------------
   // Round-robin arbitration: scan channels ptr, ptr+1, ... (mod NCH) and
   // grant the first valid one.
   // -------------------------------------------------------------------------
   logic [NCH-1:0]   w_gnt_oh;
   logic             w_gnt_any;
   logic [c_PW-1:0]  w_gnt_ch;
   logic [c_PW-1:0]  w_ptr_nxt;

   always_comb begin
      int c;
      int nx;
      c         = 0;
      nx        = 0;
      w_gnt_oh  = '0;
      w_gnt_any = 1'b0;
      w_gnt_ch  = '0;
      for (int k = 0; k < NCH; k++) begin
         c = int'(r_ptr) + k;
         if (c >= NCH) c = c - NCH;
         for (int ch = 0; ch < NCH; ch++) begin
            if ((ch == c) && !w_gnt_any && in_valid[ch]) begin
               w_gnt_any    = 1'b1;
               w_gnt_oh[ch] = 1'b1;
               w_gnt_ch     = c_PW'(ch);
            end
         end
      end
      // Next search starts just past the winner, wrapping to channel 0.
      nx = int'(w_gnt_ch) + 1;
      if (nx >= NCH) nx = 0;
      w_ptr_nxt = c_PW'(nx);
   end

   // Grants are suppressed while reset is held so no producer believes it
   // handed off a request that the reset is about to discard.
   assign in_ready = rst ? '0 : w_gnt_oh;

   // -------------------------------------------------------------------------
   // Select the granted channel's destination and data.
   // -------------------------------------------------------------------------
   logic             w_sel_gf;
   logic [AW-1:0]    w_sel_num;
   logic [WIDTH-1:0] w_sel_data;

   always_comb begin
      w_sel_gf   = 1'b0;
      w_sel_num  = '0;
      w_sel_data = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (w_gnt_oh[ch]) begin
            w_sel_gf   = in_gf[ch];
            w_sel_num  = in_num[ch*AW +: AW];
            w_sel_data = in_data[ch*WIDTH +: WIDTH];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Decoded write enable (also the scoreboard clear) and reservation set.
   // -------------------------------------------------------------------------
   logic [c_NB-1:0] w_wr_dec;
   logic [c_NB-1:0] w_rsv_dec;

   assign w_wr_dec  = w_gnt_any ? f_onehot(w_sel_gf, w_sel_num) : '0;
   assign w_rsv_dec = rsv_valid ? f_onehot(rsv_gf, rsv_num)     : '0;

   // -------------------------------------------------------------------------
   // Registered write port, pointer and scoreboard.
   // The set term is OR-ed after the clear so a reservation made in the same
   // cycle as the write-back of that register keeps it busy: the new
   // reservation belongs to a younger instruction.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr        <= '0;
         r_wr_data    <= '0;
         r_wr_enables <= '0;
         r_busy       <= '0;
      end else begin
         if (w_gnt_any) begin
            r_ptr <= w_ptr_nxt;
         end
         r_wr_enables <= w_wr_dec;
         r_wr_data    <= w_gnt_any ? w_sel_data : '0;
         r_busy       <= (r_busy & ~w_wr_dec) | w_rsv_dec;
      end
   end

   assign wr_data    = r_wr_data;
   assign wr_enables = r_wr_enables;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wb_arbiter
// Purpose  : Self-checking bench for reg_wb_arbiter. A table of per-cycle
//            input records with hand-derived grant vectors, followed by
//            hand-written sequences for the scoreboard race, reset in
//            mid-stream and the register-0 behaviour. Expected writes are
//            queued when a cycle is driven and compared one edge later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

   localparam int WIDTH = 32;
   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int NCH   = 3;

`ifdef REG_WB_ZERO_GUARD_EN
   localparam bit c_GUARD = 1'b1;
`else
   localparam bit c_GUARD = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [NCH-1:0]       in_gf;
   logic [NCH*AW-1:0]    in_num;
   logic [NCH*WIDTH-1:0] in_data;
   logic                 rsv_valid;
   logic                 rsv_gf;
   logic [AW-1:0]        rsv_num;
   logic [WIDTH-1:0]     wr_data;
   logic [2*NREG-1:0]    wr_enables;
   logic [2*NREG-1:0]    busy;

   reg_wb_arbiter #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW),
      .NCH   (NCH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_gf      (in_gf),
      .in_num     (in_num),
      .in_data    (in_data),
      .rsv_valid  (rsv_valid),
      .rsv_gf     (rsv_gf),
      .rsv_num    (rsv_num),
      .wr_data    (wr_data),
      .wr_enables (wr_enables),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  gf;
      logic [14:0] num;
      logic [95:0] data;
      logic        rv;
      logic        rgf;
      logic [4:0]  rnum;
      logic [2:0]  exp_ready;
   } vec_t;

   typedef struct {
      logic [63:0] en;
      logic [31:0] d;
   } wr_t;

   wr_t         sbq[$];
   vec_t        tbl[13];
   logic [63:0] busy_m;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] gf,
                               input logic [4:0] n0, input logic [4:0] n1,
                               input logic [4:0] n2, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic rv, input logic rgf,
                               input logic [4:0] rnum, input logic [2:0] er);
      vec_t v;
      v.valid     = valid;
      v.gf        = gf;
      v.num       = {n2, n1, n0};
      v.data      = {d2, d1, d0};
      v.rv        = rv;
      v.rgf       = rgf;
      v.rnum      = rnum;
      v.exp_ready = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [95:0] act,
                      input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // One arbitration cycle: drive, check grant, queue expected write,
   // clock, then compare the registered write and the scoreboard.
   task automatic apply(input vec_t v);
      wr_t         e;
      wr_t         g;
      logic [63:0] set_v;
      int          idx;
      in_valid  = v.valid;
      in_gf     = v.gf;
      in_num    = v.num;
      in_data   = v.data;
      rsv_valid = v.rv;
      rsv_gf    = v.rgf;
      rsv_num   = v.rnum;
      #1;
      chk("in_ready", 96'(in_ready), 96'(v.exp_ready));
      e.en  = '0;
      e.d   = '0;
      set_v = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (v.exp_ready[ch]) begin
            idx = (v.gf[ch] ? NREG : 0) + int'(v.num[ch*AW +: AW]);
            if (!(c_GUARD && idx == 0)) e.en = 64'(1) << idx;
            e.d = v.data[ch*WIDTH +: WIDTH];
         end
      end
      if (v.rv) begin
         idx = (v.rgf ? NREG : 0) + int'(v.rnum);
         if (!(c_GUARD && idx == 0)) set_v = 64'(1) << idx;
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
      end else begin
         g = sbq.pop_front();
         chk("wr_enables", 96'(wr_enables), 96'(g.en));
         chk("wr_data", 96'(wr_data), 96'(g.d));
      end
      busy_m = (busy_m & ~e.en) | set_v;
      chk("busy", 96'(busy), 96'(busy_m));
   endtask

   function automatic vec_t idle_v(input logic rv, input logic rgf,
                                   input logic [4:0] rnum);
      return mk(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                rv, rgf, rnum, 3'b000);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: run time got 100000 ns, expected completion earlier");
      $fatal(1, "timeout");
   end

   initial begin
      // Table: round-robin pointer starts at 0 after reset.
      tbl[0]  = mk(3'b001, 3'b000, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                   1'b0, 1'b0, 5'd0, 3'b001);
      tbl[1]  = idle_v(1'b0, 1'b0, 5'd0);
      tbl[2]  = mk(3'b100, 3'b100, 5'd0, 5'd0, 5'd31, 32'h0, 32'h0, 32'hA5A55A5A,
                   1'b1, 1'b1, 5'd20, 3'b100);
      tbl[3]  = idle_v(1'b1, 1'b0, 5'd10);
      tbl[4]  = mk(3'b111, 3'b100, 5'd10, 5'd10, 5'd3, 32'h100, 32'h111, 32'h222,
                   1'b1, 1'b0, 5'd9, 3'b001);
      tbl[5]  = mk(3'b111, 3'b100, 5'd10, 5'd10, 5'd3, 32'h100, 32'h111, 32'h222,
                   1'b0, 1'b0, 5'd0, 3'b010);
      tbl[6]  = mk(3'b111, 3'b100, 5'd10, 5'd10, 5'd3, 32'h100, 32'h111, 32'h222,
                   1'b0, 1'b0, 5'd0, 3'b100);
      tbl[7]  = mk(3'b111, 3'b100, 5'd10, 5'd10, 5'd3, 32'h100, 32'h111, 32'h222,
                   1'b0, 1'b0, 5'd0, 3'b001);
      tbl[8]  = mk(3'b111, 3'b100, 5'd10, 5'd10, 5'd3, 32'h100, 32'h111, 32'h222,
                   1'b0, 1'b0, 5'd0, 3'b010);
      tbl[9]  = mk(3'b011, 3'b000, 5'd10, 5'd10, 5'd0, 32'h100, 32'h111, 32'h0,
                   1'b0, 1'b0, 5'd0, 3'b001);
      tbl[10] = mk(3'b001, 3'b000, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0,
                   1'b1, 1'b0, 5'd9, 3'b001);
      tbl[11] = mk(3'b110, 3'b100, 5'd0, 5'd4, 5'd5, 32'h0, 32'h444, 32'h555,
                   1'b0, 1'b0, 5'd0, 3'b010);
      tbl[12] = mk(3'b100, 3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h555,
                   1'b0, 1'b0, 5'd0, 3'b100);

      // Reset state, with requests present to confirm no grant under reset.
      rst       = 1'b1;
      in_valid  = 3'b111;
      in_gf     = '0;
      in_num    = '0;
      in_data   = '0;
      rsv_valid = 1'b1;
      rsv_gf    = 1'b0;
      rsv_num   = 5'd3;
      busy_m    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 96'(in_ready), 96'(0));
      chk("reset_wr_enables", 96'(wr_enables), 96'(0));
      chk("reset_wr_data", 96'(wr_data), 96'(0));
      chk("reset_busy", 96'(busy), 96'(0));
      in_valid  = '0;
      rsv_valid = 1'b0;
      rst       = 1'b0;

      for (int i = 0; i < 13; i++) apply(tbl[i]);
      chk("busy9_kept", 96'(busy[9]), 96'(1));

      // Scoreboard race on float r7 (bit 39); pointer is 0 here.
      apply(idle_v(1'b1, 1'b1, 5'd7));
      chk("race_busy39_t1", 96'(busy[39]), 96'(1));
      apply(idle_v(1'b0, 1'b0, 5'd0));
      chk("race_busy39_t2", 96'(busy[39]), 96'(1));
      apply(idle_v(1'b0, 1'b0, 5'd0));
      chk("race_busy39_t3", 96'(busy[39]), 96'(1));
      apply(mk(3'b010, 3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0,
               1'b0, 1'b0, 5'd0, 3'b010));
      chk("race_busy39_t4", 96'(busy[39]), 96'(0));

      // Reset while a write from ch1 is on the output; pointer is 2 here.
      apply(mk(3'b010, 3'b000, 5'd0, 5'd12, 5'd0, 32'h0, 32'hC0FFEE, 32'h0,
               1'b1, 1'b1, 5'd1, 3'b010));
      rsv_valid = 1'b0;
      rst       = 1'b1;
      #1;
      chk("midrst_wr_enables", 96'(wr_enables), 96'(0));
      chk("midrst_wr_data", 96'(wr_data), 96'(0));
      chk("midrst_busy", 96'(busy), 96'(0));
      chk("midrst_in_ready", 96'(in_ready), 96'(0));
      busy_m = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
               1'b0, 1'b0, 5'd0, 3'b001));

      // General r0 write plus reservation of r0, then float r0 write.
      apply(mk(3'b001, 3'b000, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0,
               1'b1, 1'b0, 5'd0, 3'b001));
      apply(mk(3'b100, 3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h2,
               1'b0, 1'b0, 5'd0, 3'b100));
      chk("r0_busy0", 96'(busy[0]), 96'(c_GUARD ? 1'b0 : 1'b1));
      apply(idle_v(1'b0, 1'b0, 5'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
